bus_grant_arbiter: RTL and testbench
====================================

Name: bus_grant_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit internal bus, whose source is chosen by the 16:1 32-bit bus multiplexer.
- Accepts up to 16 bus requests, grants exactly one owner at a time, and drives the multiplexer select plus a one-hot grant vector.
- Enforces a one-cycle turnaround between owners and a maximum-hold timeout, so no requester can starve the others.

Parameters:
- NUM_REQ, 16, number of requesters; legal range 2..16.
- SEL_W, 4, width of the mux select; must satisfy 2**SEL_W >= NUM_REQ.
- MAX_HOLD, 8, maximum consecutive cycles an owner keeps the bus while another request is pending; must be >= 1.
- IDLE_SEL, 0, select value driven while the bus has no owner.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request, level-sensitive.
- freeze  in  1  when high, no new grant is issued; the current owner is unaffected.
- grant  out  NUM_REQ  one-hot grant, registered.
- sel  out  SEL_W  mux select, equal to the index of the granted requester; IDLE_SEL when no owner.
- bus_busy  out  1  high while any grant bit is set.
- preempt  out  1  single-cycle pulse when the owner is removed by the timeout.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - grant=0, sel=IDLE_SEL, bus_busy=0, preempt=0.
  - State=IDLE, hold counter=0, round-robin pointer=NUM_REQ-1, so req[0] has first priority.
  - Reset asserted mid-grant drops the grant on that same edge.
- All outputs are registered. The grant appears one cycle after arbitration, never combinationally from req.
- States:
  - IDLE: no owner.
  - OWN: grant[k]=1, sel=k.
  - TURN: one dead cycle after an owner leaves; grant=0, sel=IDLE_SEL.
- IDLE:
  - If freeze=0 and req!=0, pick the winner and go to OWN next cycle with counter=0.
  - Winner = first set req bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Otherwise stay in IDLE.
- OWN, owner k:
  - req[k]=0: release; go to TURN; pointer<=k.
  - req[k]=1, another req bit set, and counter==MAX_HOLD-1: go to TURN; pointer<=k; preempt=1 for that one cycle.
  - Otherwise stay in OWN. The counter increments only while another request is pending; otherwise it resets to 0.
  - The counter saturates and never wraps.
- TURN:
  - Always exactly one cycle.
  - Then arbitrate exactly as in IDLE, going to OWN or IDLE.
  - A preempted requester that still holds req competes again, but with the lowest priority because pointer=k.
- Boundaries:
  - Only one grant bit is ever set.
  - With a single persistent requester and no competition, the grant is held indefinitely.
  - Release and timeout in the same cycle: treated as a release, preempt=0.
  - freeze blocks only transitions into OWN. Release and timeout still apply under freeze.
  - req bits at index >= NUM_REQ do not exist. sel values >= NUM_REQ are never produced.
  - A request dropped before it is granted is simply not seen; no request is latched.
- Winner search:
  - Combinational rotate-priority over req.
  - Result is the index and a found flag.
  - Width of the index is SEL_W; arithmetic is modulo NUM_REQ and must be correct for non-power-of-two NUM_REQ.

Decomposition:
- Shared package holds:
  - The state enum (IDLE, OWN, TURN).
  - The default NUM_REQ and SEL_W constants.
  - IDLE_SEL.
- One sub-module, rr_pick: pure combinational round-robin finder.
  - Inputs: req, pointer.
  - Outputs: winner index, found.
  - Instantiated once and reused by the IDLE and TURN paths.
- The top module holds the FSM, the hold counter, the pointer and the output registers.

Test Plan:
- Reset with req=16'hFFFF: after rst_n rises, the next edge gives grant=0x0001, sel=0, bus_busy=1; while reset is held, all outputs are 0.
- Owners 0, 3 and 7 each request and hold. With MAX_HOLD=8, owner 0 keeps the bus 8 cycles, then preempt pulses, 1 TURN cycle follows, then sel=3. After that come sel=7, then sel=0 again, each following a TURN cycle.
- Single requester req=0x0020 held for 50 cycles: sel=5 throughout, preempt never asserts, the counter stays at 0.
- freeze=1 while owner 2 holds the bus and req[2] drops: TURN, then IDLE with grant=0, even though req=0x0010. freeze=0 gives grant=0x0010 on the edge after the next.
- Reset mid-grant: owner 9 active, rst_n=0 for 1 cycle. Next edge gives grant=0, sel=0; afterwards the pointer is restored, so req=0x0201 grants index 0 first.
- NUM_REQ=5 build: requesters 4 and 0 active, pointer=4. The search wraps and grants 0; sel never exceeds 4.

Source files
------------

// File: rtl/bus_grant_arbiter_pkg.sv
// Shared types and default sizing for the round-robin bus grant arbiter.
package bus_grant_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 16;
    localparam int unsigned SEL_W_DEF    = 4;
    localparam int unsigned MAX_HOLD_DEF = 8;
    localparam int unsigned IDLE_SEL_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational rotate-priority finder: first set req bit after ptr, wrapping modulo NUM_REQ.
module bus_grant_arbiter_rr_pick
    import bus_grant_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner_c,
    output logic               found_c
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        idx      = '0;
        for (int i = int'(NUM_REQ); i > 0; i--) begin
            idx = SEL_W'((int'(ptr) + i) % int'(NUM_REQ));
            if (req[idx]) begin
                winner_c = idx;
                found_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner sequencer for the shared bus: grant, mux select, turnaround and hold timeout.
module bus_grant_arbiter
    import bus_grant_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
    parameter int unsigned IDLE_SEL = IDLE_SEL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               freeze,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               bus_busy,
    output logic               preempt
);

    localparam int unsigned    CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_e             state_q,   state_d;
    logic [SEL_W-1:0]   owner_q,   owner_d;
    logic [SEL_W-1:0]   ptr_q,     ptr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic               busy_q,    busy_d;
    logic               preempt_q, preempt_d;

    logic [SEL_W-1:0]   win_c;
    logic               found_c;
    logic               others_c;
    logic               arb_c;

    bus_grant_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req      (req),
        .ptr      (ptr_q),
        .winner_c (win_c),
        .found_c  (found_c)
    );

    assign others_c = |(req & ~(NUM_REQ'(1) << owner_q));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        arb_c     = 1'b0;

        case (state_q)
            ST_OWN: begin
                // Release wins over timeout when both happen in the same cycle.
                if (!req[owner_q]) begin
                    state_d = ST_TURN;
                    ptr_d   = owner_q;
                end else if (others_c && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_TURN;
                    ptr_d     = owner_q;
                    preempt_d = 1'b1;
                end else if (others_c) begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_TURN: arb_c = 1'b1;
            default: arb_c = 1'b1;
        endcase

        if (arb_c) begin
            if (!freeze && found_c) begin
                state_d = ST_OWN;
                owner_d = win_c;
                cnt_d   = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end

        busy_d  = (state_d == ST_OWN);
        grant_d = busy_d ? (NUM_REQ'(1) << owner_d) : '0;
        sel_d   = busy_d ? owner_d : SEL_W'(IDLE_SEL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= SEL_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            sel_q     <= SEL_W'(IDLE_SEL);
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign bus_busy = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bus_grant_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        freeze;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        bus_busy;
    logic        preempt;

    logic [4:0]  req5;
    logic        freeze5;
    logic [4:0]  grant5;
    logic [2:0]  sel5;
    logic        busy5;
    logic        pre5;

    always #5 clk = ~clk;

    bus_grant_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .freeze   (freeze),
        .grant    (grant),
        .sel      (sel),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    bus_grant_arbiter #(
        .NUM_REQ  (5),
        .SEL_W    (3),
        .MAX_HOLD (8),
        .IDLE_SEL (0)
    ) dut5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req5),
        .freeze   (freeze5),
        .grant    (grant5),
        .sel      (sel5),
        .bus_busy (busy5),
        .preempt  (pre5)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: who owns the bus (-1 = nobody), last owner pointer, hold time.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    int          hist_sel  [0:40];
    bit          hist_busy [0:40];
    bit          hist_pre  [0:40];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = set request at minimal rotational distance past the pointer.
    function automatic int rr_winner(input logic [15:0] r, input int ptr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N + 1;
        for (int j = 0; j < N; j++) begin
            if (r[j]) begin
                d = (j - ptr - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = j;
                end
            end
        end
        return best;
    endfunction

    task automatic model_update();
        bit others;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_hold  = 0;
            m_pre   = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner >= 0) begin
                others = (req & ~(16'(1) << m_owner)) != 16'h0;
                if (!req[m_owner]) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                end else if (others && m_hold == MAX_HOLD - 1) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                    m_pre   = 1'b1;
                end else begin
                    m_hold = others ? m_hold + 1 : 0;
                end
            end else if (!freeze) begin
                m_owner = rr_winner(req, m_ptr);
                m_hold  = 0;
            end
        end
    endtask

    task automatic step();
        logic [31:0] exp_grant;
        @(posedge clk);
        model_update();
        #1;
        exp_grant = (m_owner >= 0) ? (32'(1) << m_owner) : 32'h0;
        chk("grant",   32'(grant),    exp_grant);
        chk("sel",     32'(sel),      (m_owner >= 0) ? 32'(m_owner) : 32'h0);
        chk("busy",    32'(bus_busy), (m_owner >= 0) ? 32'h1 : 32'h0);
        chk("preempt", 32'(preempt),  32'(m_pre));
        chk("onehot",  32'($countones(grant) <= 1), 32'h1);
        chk("sel5_range", 32'(sel5 <= 3'd4), 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        bit found;
        rst_n   = 1'b0;
        req     = 16'hFFFF;
        freeze  = 1'b0;
        req5    = 5'h0;
        freeze5 = 1'b0;

        // Reset held with every request asserted.
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel",   32'(sel),   32'h0);
        chk("rst_busy",  32'(bus_busy), 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_grant", 32'(grant), 32'h0001);
        chk("first_busy",  32'(bus_busy), 32'h1);

        // Owners 0, 3, 7 contending: timeout rotation.
        req = 16'h0089;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            step();
            hist_sel[c]  = int'(sel);
            hist_busy[c] = bus_busy;
            hist_pre[c]  = preempt;
        end
        ok = 1'b1;
        for (int c = 1; c <= 8; c++) ok &= hist_busy[c] && hist_sel[c] == 0;
        chk("own0_hold8", 32'(ok), 32'h1);
        chk("pre0_pulse", 32'(hist_pre[9]), 32'h1);
        chk("turn0_dead", 32'(hist_busy[9]), 32'h0);
        chk("own3",       32'(hist_busy[10] && hist_sel[10] == 3), 32'h1);
        chk("own7",       32'(hist_busy[19] && hist_sel[19] == 7), 32'h1);
        chk("own0_again", 32'(hist_busy[28] && hist_sel[28] == 0), 32'h1);

        // Single persistent requester is never preempted.
        req = 16'h0020;
        do_reset();
        step();
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            ok &= (sel == 4'd5) && bus_busy && !preempt;
        end
        chk("single_hold", 32'(ok), 32'h1);

        // Release and timeout in the same cycle counts as a release.
        req = 16'h0003;
        do_reset();
        step();
        for (int c = 0; c < 7; c++) step();
        req = 16'h0002;
        step();
        chk("rel_timeout_pre",  32'(preempt), 32'h0);
        chk("rel_timeout_busy", 32'(bus_busy), 32'h0);

        // Freeze blocks new grants but not the release.
        req = 16'h0004;
        do_reset();
        step();
        chk("frz_owner2", 32'(sel), 32'h2);
        freeze = 1'b1;
        req    = 16'h0010;
        step();
        chk("frz_turn", 32'(bus_busy), 32'h0);
        step();
        chk("frz_idle", 32'(grant), 32'h0);
        step();
        freeze = 1'b0;
        step();
        chk("frz_release", 32'(grant), 32'h0010);

        // Reset mid-grant drops the owner and restores the pointer.
        req = 16'h0200;
        do_reset();
        step();
        chk("mid_owner9", 32'(sel), 32'h9);
        rst_n = 1'b0;
        step();
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_sel",   32'(sel),   32'h0);
        rst_n = 1'b1;
        req   = 16'h0201;
        step();
        chk("mid_after_rst", 32'(grant), 32'h0001);

        // Five-requester build: wrap from pointer 4 to index 0.
        req = 16'h0000;
        do_reset();
        req5 = 5'h10;
        step();
        chk("n5_own4", 32'(grant5), 32'h10);
        req5  = 5'h11;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (grant5 == 5'h01) found = 1'b1;
        end
        chk("n5_wrap0", 32'(found), 32'h1);
        req5 = 5'h0;

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = ($urandom_range(0, 4) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
            end
            freeze = ($urandom_range(0, 7) == 0);
            rst_n  = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
